// File: rtl/sprite_engine.sv
// sprite_engine: clears a SCR_W x SCR_H frame buffer, draws N_SPR rectangular
// sprites at their start positions, then once per frame tick erases, moves
// and redraws each sprite in index order.
// Optional feature: define SPRITE_COLLIDE_EN to reject moves that would make
// two sprites overlap, latching a sticky per-sprite collide flag.
//
// Pixel interface: x/y/colour carry a pixel write exactly in the cycles where
// plot is high. There is no back-pressure, so the consumer must accept one
// write per clock. When plot is low, x, y and colour are driven to 0.
module sprite_engine #(
    parameter int N_SPR     = 2,
    parameter int SPR_W     = 8,
    parameter int SPR_H     = 16,
    parameter int SCR_W     = 160,
    parameter int SCR_H     = 120,
    parameter int Y_MIN     = 10,
    parameter int Y_MAX     = 100,
    parameter int FRAME_DIV = 833332
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic [N_SPR-1:0]     mv_up,
    input  logic [N_SPR-1:0]     mv_dn,
    input  logic [N_SPR-1:0]     mv_lf,
    input  logic [N_SPR-1:0]     mv_rt,
    input  logic [8*N_SPR-1:0]   init_x,
    input  logic [8*N_SPR-1:0]   init_y,
    input  logic [8*N_SPR-1:0]   x_min,
    input  logic [8*N_SPR-1:0]   x_max,
    input  logic [3*N_SPR-1:0]   spr_colour,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 overrun,
    output logic [N_SPR-1:0]     collide,
    output logic [2:0]           state_dbg
);

    localparam int IDX_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int SLOTS = 1 << IDX_W;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [3:0]       COL_LAST = 4'(SPR_W - 1);
    localparam logic [3:0]       ROW_LAST = 4'(SPR_H - 1);
    localparam logic [7:0]       CX_LAST  = 8'(SCR_W - 1);
    localparam logic [6:0]       CY_LAST  = 7'(SCR_H - 1);
    localparam logic [IDX_W-1:0] SPR_LAST = IDX_W'(N_SPR - 1);
    localparam logic [7:0]       Y_LO     = 8'(Y_MIN);
    localparam logic [7:0]       Y_HI     = 8'(Y_MAX);

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ERASE  = 3'd3,
        S_UPDATE = 3'd4,
        S_DRAW   = 3'd5
    } state_t;

    state_t           state, state_nx;
    logic             started;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [7:0]       cx;
    logic [6:0]       cy;
    logic [3:0]       col, row;
    logic [IDX_W-1:0] spr;
    logic [7:0]       pos_x [SLOTS];
    logic [7:0]       pos_y [SLOTS];
    logic             pending;
    logic             overrun_q;

    logic       spr_last_px, clr_last, last_spr;
    logic [7:0] cur_x, cur_y, ini_x, ini_y, lim_lo, lim_hi;
    logic [2:0] cur_col;
    logic       want_l, want_r, want_u, want_d;
    logic [7:0] cand_x, cand_y, new_x, new_y;

    assign tick        = (div_cnt == DIV_LAST);
    assign spr_last_px = (col == COL_LAST) && (row == ROW_LAST);
    assign clr_last    = (cx == CX_LAST) && (cy == CY_LAST);
    assign last_spr    = (spr == SPR_LAST);
    assign busy        = (state != S_IDLE);
    assign overrun     = overrun_q;
    assign state_dbg   = state;

    // Fields of the sprite currently addressed by spr.
    always_comb begin
        cur_x   = pos_x[spr];
        cur_y   = pos_y[spr];
        ini_x   = init_x[8*spr +: 8];
        ini_y   = init_y[8*spr +: 8];
        lim_lo  = x_min[8*spr +: 8];
        lim_hi  = x_max[8*spr +: 8];
        cur_col = spr_colour[3*spr +: 3];
    end

`ifdef SPRITE_COLLIDE_EN
    logic             hit_x, hit_y, upd_hit;
    logic [N_SPR-1:0] collide_q;

    function automatic logic overlap(input logic [7:0] ax, input logic [7:0] ay,
                                     input logic [7:0] bx, input logic [7:0] by);
        return ({1'b0, ax} < {1'b0, bx} + 9'(SPR_W)) &&
               ({1'b0, bx} < {1'b0, ax} + 9'(SPR_W)) &&
               ({1'b0, ay} < {1'b0, by} + 9'(SPR_H)) &&
               ({1'b0, by} < {1'b0, ay} + 9'(SPR_H));
    endfunction
`endif

    // Bounded one-step move for the current sprite; opposing requests cancel.
    always_comb begin
        want_l = mv_lf[spr] & ~mv_rt[spr];
        want_r = mv_rt[spr] & ~mv_lf[spr];
        want_u = mv_up[spr] & ~mv_dn[spr];
        want_d = mv_dn[spr] & ~mv_up[spr];
        cand_x = cur_x;
        cand_y = cur_y;
        if (want_l && (cur_x > lim_lo))
            cand_x = cur_x - 8'd1;
        else if (want_r && (cur_x < lim_hi))
            cand_x = cur_x + 8'd1;
        if (want_u && (cur_y > Y_LO))
            cand_y = cur_y - 8'd1;
        else if (want_d && (cur_y < Y_HI))
            cand_y = cur_y + 8'd1;
`ifdef SPRITE_COLLIDE_EN
        hit_x = 1'b0;
        hit_y = 1'b0;
        for (int j = 0; j < N_SPR; j++) begin
            if (IDX_W'(j) != spr) begin
                if ((cand_x != cur_x) && overlap(cand_x, cur_y, pos_x[j], pos_y[j]))
                    hit_x = 1'b1;
                if ((cand_y != cur_y) && overlap(cur_x, cand_y, pos_x[j], pos_y[j]))
                    hit_y = 1'b1;
            end
        end
        new_x   = hit_x ? cur_x : cand_x;
        new_y   = hit_y ? cur_y : cand_y;
        upd_hit = hit_x | hit_y;
`else
        new_x = cand_x;
        new_y = cand_y;
`endif
    end

    // First clock after reset release arms pixel output.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) started <= 1'b0;
        else         started <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= S_CLEAR;
        else         state <= state_nx;
    end

    // FSM next-state logic; clear overrides every transition.
    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR:  if (started && clr_last) state_nx = S_INIT;
            S_INIT:   if (spr_last_px && last_spr) state_nx = S_IDLE;
            S_IDLE:   if (tick || pending) state_nx = S_ERASE;
            S_ERASE:  if (spr_last_px) state_nx = S_UPDATE;
            S_UPDATE: state_nx = S_DRAW;
            S_DRAW:   if (spr_last_px) state_nx = last_spr ? S_IDLE : S_ERASE;
            default:  state_nx = S_CLEAR;
        endcase
        if (clear) state_nx = S_CLEAR;
    end

    // Scan counters, sprite index and sprite positions.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cx  <= '0;
            cy  <= '0;
            col <= '0;
            row <= '0;
            spr <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                pos_x[k] <= '0;
                pos_y[k] <= '0;
            end
        end else if (clear) begin
            cx  <= '0;
            cy  <= '0;
            col <= '0;
            row <= '0;
            spr <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (started) begin
                        if (cx == CX_LAST) begin
                            cx <= '0;
                            cy <= (cy == CY_LAST) ? 7'd0 : cy + 7'd1;
                        end else begin
                            cx <= cx + 8'd1;
                        end
                    end
                end
                S_INIT, S_ERASE, S_DRAW: begin
                    if (state == S_INIT) begin
                        pos_x[spr] <= ini_x;
                        pos_y[spr] <= ini_y;
                    end
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            row <= '0;
                            if (state != S_ERASE)
                                spr <= last_spr ? '0 : spr + IDX_W'(1);
                        end else begin
                            row <= row + 4'd1;
                        end
                    end else begin
                        col <= col + 4'd1;
                    end
                end
                S_UPDATE: begin
                    pos_x[spr] <= new_x;
                    pos_y[spr] <= new_y;
                end
                default: ;
            endcase
        end
    end

    // Free-running frame divider, never paused or cleared by the FSM.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) div_cnt <= '0;
        else         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end

    // One-deep tick queue while a pass runs; a second queued tick is dropped.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pending   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (clear) begin
                pending <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: pending <= 1'b0;
                    S_ERASE, S_UPDATE, S_DRAW: begin
                        if (tick) begin
                            if (pending) overrun_q <= 1'b1;
                            else         pending   <= 1'b1;
                        end
                    end
                    default: pending <= 1'b0;
                endcase
            end
        end
    end

`ifdef SPRITE_COLLIDE_EN
    // Sticky collision flags, set when UPDATE rejects a move.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            collide_q <= '0;
        else if (clear)
            collide_q <= '0;
        else if ((state == S_UPDATE) && upd_hit)
            collide_q[spr] <= 1'b1;
    end
    assign collide = collide_q;
`else
    assign collide = '0;
`endif

    // Pixel output mux; everything is 0 when no write is issued.
    always_comb begin
        x      = '0;
        y      = '0;
        colour = '0;
        plot   = 1'b0;
        case (state)
            S_CLEAR: begin
                if (started) begin
                    plot = 1'b1;
                    x    = cx;
                    y    = cy;
                end
            end
            S_INIT: begin
                plot   = 1'b1;
                x      = ini_x + {4'b0, col};
                y      = ini_y[6:0] + {3'b0, row};
                colour = cur_col;
            end
            S_ERASE: begin
                plot = 1'b1;
                x    = cur_x + {4'b0, col};
                y    = cur_y[6:0] + {3'b0, row};
            end
            S_DRAW: begin
                plot   = 1'b1;
                x      = cur_x + {4'b0, col};
                y      = cur_y[6:0] + {3'b0, row};
                colour = cur_col;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: directed moves on two sprites, an expected pixel
// queue filled by the driver and drained by a monitor on every plot cycle.
module tb_sprite_engine;

    localparam logic [2:0] ST_CLEAR  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_DRAW   = 3'd5;

    logic        clk;
    logic        resetn;
    logic        clear;
    logic [1:0]  mv_up, mv_dn, mv_lf, mv_rt;
    logic [15:0] init_x, init_y, x_min, x_max;
    logic [5:0]  spr_colour;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, overrun;
    logic [1:0]  collide;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt  = 0;

    logic [17:0] exp_q[$];

    // Sprite positions after pass k (k = 0 is the INIT placement).
    int tx0[7] = '{30, 30, 30, 30, 31, 31, 31};
    int ty0[7] = '{100, 100, 100, 100, 100, 100, 100};
    int tx1[7] = '{20, 19, 18, 17, 17, 17, 17};
    int ty1[7] = '{50, 49, 48, 47, 47, 47, 47};

    sprite_engine #(.N_SPR(2), .FRAME_DIV(300)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .clear      (clear),
        .mv_up      (mv_up),
        .mv_dn      (mv_dn),
        .mv_lf      (mv_lf),
        .mv_rt      (mv_rt),
        .init_x     (init_x),
        .init_y     (init_y),
        .x_min      (x_min),
        .x_max      (x_max),
        .spr_colour (spr_colour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .overrun    (overrun),
        .collide    (collide),
        .state_dbg  (state_dbg)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic push_rect(input int px, input int py, input logic [2:0] c);
        logic [7:0] xv;
        logic [6:0] yv;
        for (int r = 0; r < 16; r++) begin
            for (int cc = 0; cc < 8; cc++) begin
                xv = 8'(px + cc);
                yv = 7'(py + r);
                exp_q.push_back({xv, yv, c});
            end
        end
    endtask

    task automatic push_clear();
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                exp_q.push_back({8'(xx), 7'(yy), 3'd0});
    endtask

    task automatic push_pass(input int k);
        push_rect(tx0[k-1], ty0[k-1], 3'd0);
        push_rect(tx0[k],   ty0[k],   3'd5);
        push_rect(tx1[k-1], ty1[k-1], 3'd0);
        push_rect(tx1[k],   ty1[k],   3'd3);
    endtask

    // Returns at the negedge of the n-th cycle that enters IDLE.
    task automatic wait_idle_entries(input int n, input string name);
        int   seen;
        int   cycles;
        logic prev;
        seen   = 0;
        cycles = 0;
        prev   = (state_dbg == ST_IDLE);
        while ((seen < n) && (cycles < 40000)) begin
            @(negedge clk);
            cycles++;
            if ((state_dbg == ST_IDLE) && !prev) seen++;
            prev = (state_dbg == ST_IDLE);
        end
        check(name, seen, n);
    endtask

    // Monitor: pops one expected pixel per plot cycle, checks quiet states.
    always @(negedge clk) begin
        logic [17:0] e;
        if (resetn) begin
            if (plot) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL pixel_extra got x=%0d y=%0d c=%0d expected no write", x, y, colour);
                end else begin
                    e = exp_q.pop_front();
                    if ({x, y, colour} !== e) begin
                        n_errors++;
                        $display("FAIL pixel got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                                 x, y, colour, e[17:10], e[9:3], e[2:0]);
                    end
                end
            end
            if (overrun) ovr_cnt++;
            if (state_dbg == ST_UPDATE) begin
                n_checks++;
                if ({plot, x, y, colour} !== 19'd0) begin
                    n_errors++;
                    $display("FAIL update_quiet got plot=%0d x=%0d y=%0d c=%0d expected all 0",
                             plot, x, y, colour);
                end
            end
        end
    end

    // Driver: directed scenario.
    initial begin
        int cyc;
        int exp_x0;
        logic [1:0] exp_col;
        resetn     = 1'b0;
        clear      = 1'b0;
        mv_dn      = 2'b01;
        mv_up      = 2'b10;
        mv_lf      = 2'b10;
        mv_rt      = 2'b00;
        init_x     = {8'd20, 8'd30};
        init_y     = {8'd50, 8'd100};
        x_min      = {8'd5, 8'd5};
        x_max      = {8'd140, 8'd31};
        spr_colour = {3'd3, 3'd5};

        repeat (3) @(negedge clk);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_overrun", overrun, 0);
        check("rst_collide", collide, 0);
        check("rst_busy", busy, 1);
        check("rst_state", state_dbg, ST_CLEAR);

        push_clear();
        push_rect(30, 100, 3'd5);
        push_rect(20, 50, 3'd3);
        for (int k = 1; k <= 6; k++) push_pass(k);

        resetn = 1'b1;
        @(negedge clk);
        check("busy_after_reset", busy, 1);

        wait_idle_entries(1, "idle_after_init");
        check("idle_plot", plot, 0);
        check("idle_xyc", {x, y, colour}, 0);
        check("idle_busy", busy, 0);
        check("init_pixels_done", exp_q.size(), 6 * 512);

        wait_idle_entries(1, "idle_after_pass1");
        check("overrun_pass1", ovr_cnt, 0);
        wait_idle_entries(1, "idle_after_pass2");
        check("overrun_pass2", ovr_cnt, 1);
        wait_idle_entries(1, "idle_after_pass3");
        check("idle_busy_p3", busy, 0);

        mv_rt = 2'b11;
        mv_lf = 2'b10;
        mv_up = 2'b10;
        mv_dn = 2'b10;
        wait_idle_entries(2, "idle_after_pass5");
        check("collide_phase_a", collide, 0);
        check("pass5_pixels_done", exp_q.size(), 512);

        cyc = 0;
        while (!((state_dbg == ST_DRAW) && plot && (colour == 3'd3)) && (cyc < 2000)) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_draw1", (cyc < 2000), 1);
        repeat (20) @(negedge clk);
        clear  = 1'b1;
        init_x = {8'd22, 8'd30};
        init_y = {8'd50, 8'd50};
        mv_up  = 2'b00;
        mv_dn  = 2'b00;
        mv_rt  = 2'b00;
        mv_lf  = 2'b01;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_busy", busy, 1);
        check("clear_state", state_dbg, ST_CLEAR);
        check("clear_first_px", {plot, x, y, colour}, {1'b1, 18'd0});
        exp_q.delete();

`ifdef SPRITE_COLLIDE_EN
        exp_x0  = 30;
        exp_col = 2'b01;
`else
        exp_x0  = 29;
        exp_col = 2'b00;
`endif
        push_clear();
        push_rect(30, 50, 3'd5);
        push_rect(22, 50, 3'd3);
        push_rect(30, 50, 3'd0);
        push_rect(exp_x0, 50, 3'd5);
        push_rect(22, 50, 3'd0);
        push_rect(22, 50, 3'd3);

        wait_idle_entries(2, "idle_after_pass7");
        check("collide_final", collide, exp_col);
        check("queue_drained", exp_q.size(), 0);
        check("final_idle_plot", plot, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 Parameter N_SPR, default 2, number of independently moved rectangular sprites (1..8).
REQ-002 Parameter SPR_W, default 8, sprite width in pixels (1..16).
REQ-003 Parameter SPR_H, default 16, sprite height in pixels (1..16).
REQ-004 Parameters SCR_W/SCR_H, default 160/120, screen size in pixels.
REQ-005 Parameters Y_MIN/Y_MAX, default 10/100, vertical travel bounds of each sprite's top-left corner, inclusive.
REQ-006 Parameter FRAME_DIV, default 833332, CLOCK_50 cycles per frame tick, giving about 60 Hz.
REQ-007 CLOCK_50  in  1  system clock, rising edge.
REQ-008 resetn  in  1  asynchronous active-low reset.
REQ-009 clear  in  1  synchronous restart: repaint the screen and re-load the initial positions.
REQ-010 mv_up, mv_dn, mv_lf, mv_rt  in  N_SPR each  per-sprite move requests, active-high, level-sampled.
REQ-011 init_x/init_y  in  8*N_SPR each  per-sprite start position, sampled in INIT.
REQ-012 x_min/x_max  in  8*N_SPR each  per-sprite horizontal bounds, inclusive.
REQ-013 spr_colour  in  3*N_SPR  per-sprite RGB colour.
REQ-014 x  out  8  pixel column.
REQ-015 y  out  7  pixel row.
REQ-016 colour  out  3  pixel colour.
REQ-017 plot  out  1  the x/y/colour outputs form a valid pixel write this cycle.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 overrun  out  1  one-cycle pulse when a frame tick is dropped.
REQ-020 collide  out  N_SPR  per-sprite collision flags.

Function
REQ-021 FSM states: CLEAR, INIT, IDLE, ERASE, UPDATE, DRAW; a sprite index i (0..N_SPR-1) qualifies ERASE, UPDATE and DRAW.
REQ-022 CLEAR emits SCR_W*SCR_H pixels in row-major order with colour 0 and plot 1, then goes to INIT.
REQ-023 INIT loads each position from init_x/init_y, draws all sprites in index order, then goes to IDLE.
REQ-024 Sprite pixel order is row-major: column counter 0..SPR_W-1 inner, row counter 0..SPR_H-1 outer; pixel = (pos_x+col, pos_y+row).
REQ-025 ERASE(i): SPR_W*SPR_H cycles with colour 0 and plot 1, then UPDATE(i).
REQ-026 UPDATE(i): exactly 1 cycle with plot 0; it applies at most +/-1 in x and +/-1 in y, then goes to DRAW(i).
REQ-027 A move is applied only if the result stays within the bounds (Y_MIN..Y_MAX, x_min[i]..x_max[i]); otherwise that axis is unchanged.
REQ-028 mv_up and mv_dn both high: no y move; mv_lf and mv_rt both high: no x move.
REQ-029 DRAW(i): SPR_W*SPR_H cycles in spr_colour[i] with plot 1; then ERASE(i+1), or IDLE after the last sprite.
REQ-030 Frame timing: IDLE to ERASE(0) on a frame tick; one frame pass takes N_SPR*(2*SPR_W*SPR_H+1) cycles.
REQ-031 A tick arriving while busy sets a single pending flag; the pass starts on IDLE entry.
REQ-032 A tick arriving while the pending flag is already set is dropped and pulses overrun.
REQ-033 The frame divider runs continuously in every state.
REQ-034 In CLEAR and INIT, ticks are discarded without asserting overrun.
REQ-035 clear has priority over all states: next cycle the FSM is in CLEAR with its counters zeroed and the pending flag cleared.
REQ-036 plot is 0 in IDLE and UPDATE, and x, y and colour then hold 0.

Reset
REQ-037 While resetn=0: x=0, y=0, colour=0, plot=0, overrun=0, collide=0, all positions=0, pending=0, divider=0.
REQ-038 busy is 1 during and after reset, because the FSM enters CLEAR on resetn rising.
REQ-039 Reset asserted mid-pass aborts immediately; no partial sprite state is retained.

Configuration
REQ-040 Macro SPRITE_COLLIDE_EN defined: in UPDATE(i), an x or y move is rejected if the new rectangle would overlap any other sprite's current rectangle.
REQ-041 With SPRITE_COLLIDE_EN defined, a rejection sets collide[i], which stays sticky until clear or reset.
REQ-042 Macro SPRITE_COLLIDE_EN undefined: collide is tied to 0 and overlap is permitted.

Verification
REQ-043 Check: reset release, defaults -> exactly 19200 plot cycles of colour 0, then sprite 0 drawn at init, 128 pixels in spr_colour[0].
REQ-044 Check: sprite 0 at y=100, mv_dn held for 3 ticks -> y stays 100; erase/draw rectangle unchanged.
REQ-045 Check: mv_up and mv_lf both high on sprite 1 at (20,50) -> after one tick, DRAW(1) starts at (19,49).
REQ-046 Check: FRAME_DIV=300, N_SPR=2 (pass = 514 cycles) -> first extra tick sets pending, second pulses overrun once.
REQ-047 Check: clear asserted mid-DRAW(1) -> next cycle busy=1, first pixel (0,0) colour 0, positions re-loaded from init.
REQ-048 Check (SPRITE_COLLIDE_EN): sprite 0 at (30,50), sprite 1 at (22,50), mv_lf on sprite 0 -> x stays 30, collide[0]=1.
